int_request_ctrl: RTL

INT_REQUEST_CTRL -- requirements
Module: int_request_ctrl

---
 rtl/int_request_ctrl_pkg.sv | 29 ++
 rtl/int_request_ctrl_sync.sv | 41 ++++
 rtl/int_request_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/int_request_ctrl_pkg.sv
// Shared constants for the interrupt request controller: register map,
// service-state encodings and the vector priority encoder.
package int_request_ctrl_pkg;

    // CPU register port addresses
    localparam logic [1:0] INTC_ADDR_PEND   = 2'd0;
    localparam logic [1:0] INTC_ADDR_MASK   = 2'd1;
    localparam logic [1:0] INTC_ADDR_VEC    = 2'd2;
    localparam logic [1:0] INTC_ADDR_STATUS = 2'd3;

    // Service state is encoded directly as {INS1, INS0}
    typedef enum logic [1:0] {
        INTC_STATE_IDLE   = 2'b00,
        INTC_STATE_SVC0   = 2'b01,
        INTC_STATE_SVC1   = 2'b10,
        INTC_STATE_SVC1_0 = 2'b11
    } intc_state_e;

    // Lowest-index asserted request among sources 1..7; 0 when none
    function automatic logic [2:0] intc_lowest_src(input logic [7:1] req);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (req[i]) id = i[2:0];
        end
        return id;
    endfunction

endpackage

// File: rtl/int_request_ctrl_sync.sv
// Per-line synchronizer and set-event qualifier for one IRQ input.
// Build option INTC_EDGE_EN: set event only on a synchronized 0->1 edge;
// otherwise a set event is raised every cycle the synchronized line is high.
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    output logic set_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchronizer chain; bit 0 samples the asynchronous line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
        end
    end

`ifdef INTC_EDGE_EN
    logic prev_q;

    // Delayed copy of the synchronized line for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign set_o = sync_q[SYNC_STAGES-1] & ~prev_q;
`else
    assign set_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request controller: eight synchronized IRQ lines (bit 0 NMI),
// pending/mask registers, two-level service tracking and CPU register port.
// Build option INTC_EDGE_EN selects edge-triggered pending (default: level).
module int_request_ctrl
    import int_request_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IRQ,
    input  logic       COMMIT,
    input  logic       ACK0,
    input  logic       ACK1,
    input  logic       RETI,
    output logic       INT0,
    output logic       INT1,
    input  logic       SEL,
    input  logic       WR,
    input  logic [1:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT
);

    logic [7:0]  irq_set;
    logic [7:0]  pend_q, pend_d, pend_clr;
    logic [7:1]  mask_q, mask_d;
    logic [2:0]  vec_q, vec_d;
    logic        int0_q, int0_d, int1_q, int1_d;
    intc_state_e state_q, state_d;
    logic        ins0, ins1;
    logic [7:1]  req_unmasked;
    logic        any_req;
    logic [2:0]  ack1_id;
    logic [7:0]  ack1_onehot;
    logic        reti_fire, ack0_fire, ack1_fire, reg_wr;

    for (genvar g = 0; g < 8; g++) begin : g_sync
        irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i (CLK),
            .rst_i (RESET),
            .irq_i (IRQ[g]),
            .set_o (irq_set[g])
        );
    end

    assign req_unmasked = pend_q[7:1] & mask_q[7:1];
    assign any_req      = |req_unmasked;
    assign ack1_id      = intc_lowest_src(req_unmasked);
    assign ack1_onehot  = 8'b1 << ack1_id;
    assign reg_wr       = SEL & WR;

    // RETI wins over a same-cycle ACK so state and PEND stay consistent;
    // ACK0 (NMI) wins over ACK1 if both arrive together in IDLE.
    assign reti_fire = COMMIT & RETI & (state_q != INTC_STATE_IDLE);
    assign ack0_fire = COMMIT & ACK0 & ~ins0 & pend_q[0] & ~reti_fire;
    assign ack1_fire = COMMIT & ACK1 & ~ins0 & ~ins1 & any_req & ~ack0_fire;

    // Service state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= INTC_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Service state transitions on qualified ACK/RETI
    always_comb begin
        state_d = state_q;
        case (state_q)
            INTC_STATE_IDLE: begin
                if (ack0_fire)      state_d = INTC_STATE_SVC0;
                else if (ack1_fire) state_d = INTC_STATE_SVC1;
            end
            INTC_STATE_SVC1: begin
                if (reti_fire)      state_d = INTC_STATE_IDLE;
                else if (ack0_fire) state_d = INTC_STATE_SVC1_0;
            end
            INTC_STATE_SVC0: begin
                if (reti_fire)      state_d = INTC_STATE_IDLE;
            end
            INTC_STATE_SVC1_0: begin
                if (reti_fire)      state_d = INTC_STATE_SVC1;
            end
            default:                state_d = INTC_STATE_IDLE;
        endcase
    end

    // In-service flags decoded from the service state
    always_comb begin
        ins0 = 1'b0;
        ins1 = 1'b0;
        case (state_q)
            INTC_STATE_SVC0:   ins0 = 1'b1;
            INTC_STATE_SVC1:   ins1 = 1'b1;
            INTC_STATE_SVC1_0: begin
                ins0 = 1'b1;
                ins1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Next values of pending, mask, vector and request outputs
    always_comb begin
        pend_clr = 8'h00;
        if (ack0_fire) pend_clr[0] = 1'b1;
        if (ack1_fire) pend_clr    = pend_clr | ack1_onehot;
        if (reg_wr && ADDR == INTC_ADDR_PEND) pend_clr = pend_clr | DIN;
        // A set event in the same cycle as a clear leaves the bit pending
        pend_d = (pend_q & ~pend_clr) | irq_set;

        mask_d = mask_q;
        if (reg_wr && ADDR == INTC_ADDR_MASK) mask_d = DIN[7:1];

        vec_d = vec_q;
        if (ack1_fire) begin
            vec_d = ack1_id;
        end else if (reti_fire && state_q == INTC_STATE_SVC1) begin
            vec_d = 3'd0;
        end

        int0_d = pend_q[0] & ~ins0;
        int1_d = any_req & ~ins1 & ~ins0;
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_q <= 8'h00;
            mask_q <= 7'h00;
            vec_q  <= 3'd0;
            int0_q <= 1'b0;
            int1_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            vec_q  <= vec_d;
            int0_q <= int0_d;
            int1_q <= int1_d;
        end
    end

    assign INT0 = int0_q;
    assign INT1 = int1_q;

    // Combinational register read mux
    always_comb begin
        DOUT = 8'h00;
        if (SEL) begin
            case (ADDR)
                INTC_ADDR_PEND:   DOUT = pend_q;
                INTC_ADDR_MASK:   DOUT = {mask_q, 1'b1};
                INTC_ADDR_VEC:    DOUT = {5'b0, vec_q};
                INTC_ADDR_STATUS: DOUT = {6'b0, ins1, ins0};
                default:          DOUT = 8'h00;
            endcase
        end
    end

endmodule
